vip_frame_sequencer: RTL and testbench

VIP_FRAME_SEQUENCER -- requirements
Module: vip_frame_sequencer

---
 rtl/vip_frame_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_vip_frame_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_frame_sequencer.sv
// Frame sequencer for a VIP-style video block: control handshake, then beat-counted read/write pacing.
// Latency: read is combinational; write follows read by PIPE_LATENCY unstalled cycles; send is registered.
// Backpressure: stall_out freezes reads and the valid pipe (no beat lost/duplicated); stall_in only gates reads.
//
// Ports:
//   clk, rst                      - single clock, asynchronous active-high reset
//   vip_ctrl_valid, width_in,
//   height_in, interlaced_in      - decoded control packet (sampled only in IDLE)
//   stall_in, stall_out           - input beat unavailable / encoder cannot accept a beat
//   vip_ctrl_busy                 - encoder is emitting a control packet
//   read, write                   - consume an input beat / present an output beat this cycle
//   vip_ctrl_send                 - one-cycle request for the encoder to send the control packet
//   width_out, height_out,
//   interlaced_out                - frame parameters latched from the accepted control packet
//   end_of_video_out              - coincides with the final write of a frame
//   frame_active                  - high while beats are being moved (ACTIVE or DRAIN)
//   timeout_err                   - sticky stall-watchdog flag
//
// Build option: define VIP_SEQ_TIMEOUT_EN to include the stall watchdog; otherwise
// timeout_err is tied low and a stalled frame waits indefinitely.
module vip_frame_sequencer #(
  parameter int PIPE_LATENCY   = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vip_ctrl_valid,
  input  logic [15:0] width_in,
  input  logic [15:0] height_in,
  input  logic [3:0]  interlaced_in,
  input  logic        stall_in,
  input  logic        stall_out,
  input  logic        vip_ctrl_busy,
  output logic        read,
  output logic        write,
  output logic        vip_ctrl_send,
  output logic [15:0] width_out,
  output logic [15:0] height_out,
  output logic [3:0]  interlaced_out,
  output logic        end_of_video_out,
  output logic        frame_active,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_CTRL,
    WAIT_CTRL,
    ACTIVE,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [15:0] width;
    logic [15:0] height;
    logic [3:0]  interlaced;
  } frame_hdr_t;

  state_t                  state;
  frame_hdr_t              hdr;
  logic [31:0]             total;
  logic [31:0]             in_cnt;
  logic [31:0]             out_cnt;
  logic [PIPE_LATENCY-1:0] vld_pipe;

  logic in_frame;
  logic tail_vld;
  logic last_read;
  logic last_beat;
  logic wd_fire;

  assign in_frame  = (state == ACTIVE) || (state == DRAIN);
  assign tail_vld  = vld_pipe[PIPE_LATENCY-1];

  assign read      = (state == ACTIVE) && !stall_in && !stall_out && (in_cnt < total);
  // The tail beat is only released when the encoder can take it; otherwise it
  // stays parked in the (frozen) valid pipe.
  assign write     = tail_vld && !stall_out;

  assign last_read = read && ((in_cnt + 32'd1) == total);
  assign last_beat = in_frame && write && ((out_cnt + 32'd1) == total);

  assign end_of_video_out = last_beat;
  assign frame_active     = in_frame;
  assign width_out        = hdr.width;
  assign height_out       = hdr.height;
  assign interlaced_out   = hdr.interlaced;

`ifdef VIP_SEQ_TIMEOUT_EN
  // Counts consecutive in-frame cycles with no beat movement in either direction.
  logic [31:0] wd_cnt;
  logic        wd_idle;

  assign wd_idle = in_frame && !read && !write;
  assign wd_fire = wd_idle && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (!wd_idle || wd_fire) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 32'd1;
      end
      if (wd_fire) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      hdr           <= '0;
      total         <= '0;
      in_cnt        <= '0;
      out_cnt       <= '0;
      vld_pipe      <= '0;
      vip_ctrl_send <= 1'b0;
    end else begin
      vip_ctrl_send <= 1'b0;

      // Pipe advances in lockstep with the encoder; a stall freezes every stage.
      if (!stall_out) begin
        vld_pipe <= (vld_pipe << 1) | PIPE_LATENCY'(read);
      end
      if (read) begin
        in_cnt <= in_cnt + 32'd1;
      end
      if (write) begin
        out_cnt <= out_cnt + 32'd1;
      end

      case (state)
        IDLE: begin
          if (vip_ctrl_valid && (width_in != 16'd0) && (height_in != 16'd0)) begin
            hdr   <= '{width: width_in, height: height_in, interlaced: interlaced_in};
            total <= {16'd0, width_in} * {16'd0, height_in};
            state <= SEND_CTRL;
          end
        end
        SEND_CTRL: begin
          if (!vip_ctrl_busy) begin
            vip_ctrl_send <= 1'b1;
            state         <= WAIT_CTRL;
          end
        end
        WAIT_CTRL: begin
          if (!vip_ctrl_busy) begin
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (last_read) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Frame completion (or watchdog expiry) overrides the per-state update and
      // leaves the datapath clean for the next control packet.
      if (last_beat || wd_fire) begin
        state    <= IDLE;
        in_cnt   <= '0;
        out_cnt  <= '0;
        vld_pipe <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vip_frame_sequencer.sv
// Directed bench for vip_frame_sequencer: nominal frame, output stall, zero-size/busy handshake, mid-frame reset.
// Latency: samples DUT outputs on the falling edge; drives inputs 1 time unit after the rising edge.
// Backpressure: stall_out / vip_ctrl_busy / stall_in are driven directly from the stimulus sequence.
module tb_vip_frame_sequencer;

  logic        clk;
  logic        rst;
  logic        vip_ctrl_valid;
  logic [15:0] width_in;
  logic [15:0] height_in;
  logic [3:0]  interlaced_in;
  logic        stall_in;
  logic        stall_out;
  logic        vip_ctrl_busy;
  logic        read;
  logic        write;
  logic        vip_ctrl_send;
  logic [15:0] width_out;
  logic [15:0] height_out;
  logic [3:0]  interlaced_out;
  logic        end_of_video_out;
  logic        frame_active;
  logic        timeout_err;

  vip_frame_sequencer #(
    .PIPE_LATENCY   (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .vip_ctrl_valid   (vip_ctrl_valid),
    .width_in         (width_in),
    .height_in        (height_in),
    .interlaced_in    (interlaced_in),
    .stall_in         (stall_in),
    .stall_out        (stall_out),
    .vip_ctrl_busy    (vip_ctrl_busy),
    .read             (read),
    .write            (write),
    .vip_ctrl_send    (vip_ctrl_send),
    .width_out        (width_out),
    .height_out       (height_out),
    .interlaced_out   (interlaced_out),
    .end_of_video_out (end_of_video_out),
    .frame_active     (frame_active),
    .timeout_err      (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Per-frame observations; cycle numbers are relative to the first frame_active cycle.
  int   cyc       = 0;
  int   act_start = 0;
  int   f_rd, f_wr, f_eov, eov_idx;
  int   first_rd, last_rd, first_wr, wr2, last_wr;
  int   stall_cyc, stall_rd, stall_wr;
  int   send_cnt  = 0;
  logic fa_q      = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock: sample at the falling edge, return 1 unit after the next rising edge.
  task automatic step();
    @(negedge clk);
    if (frame_active && !fa_q) begin
      act_start = cyc;
      f_rd = 0; f_wr = 0; f_eov = 0; eov_idx = 0;
      first_rd = -1; last_rd = -1; first_wr = -1; wr2 = -1; last_wr = -1;
      stall_cyc = 0; stall_rd = 0; stall_wr = 0;
    end
    fa_q = frame_active;
    if (vip_ctrl_send) send_cnt++;
    if (frame_active && stall_out) begin
      stall_cyc++;
      if (read)  stall_rd++;
      if (write) stall_wr++;
    end
    if (read) begin
      if (f_rd == 0) first_rd = cyc - act_start;
      last_rd = cyc - act_start;
      f_rd++;
    end
    if (write) begin
      f_wr++;
      if (f_wr == 1) first_wr = cyc - act_start;
      if (f_wr == 2) wr2 = cyc - act_start;
      last_wr = cyc - act_start;
      if (end_of_video_out) begin
        f_eov++;
        eov_idx = f_wr;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
    vip_ctrl_valid = 1'b1;
    width_in       = w;
    height_in      = h;
    interlaced_in  = il;
    step();
    vip_ctrl_valid = 1'b0;
    width_in       = 16'd0;
    height_in      = 16'd0;
    interlaced_in  = 4'd0;
  endtask

  task automatic wait_active(input string tag, input int budget);
    int n = 0;
    while (!frame_active && n < budget) begin
      step();
      n++;
    end
    check(tag, frame_active, 1'b1);
  endtask

  task automatic wait_frame_done(input string tag, input int budget);
    int n = 0;
    while (!frame_active && n < budget) begin
      step();
      n++;
    end
    while (frame_active && n < budget) begin
      step();
      n++;
    end
    check(tag, (n < budget), 1'b1);
  endtask

  task automatic check_rst_outputs(input string tag);
    check({tag, "_rd_wr_send"}, {read, write, vip_ctrl_send}, 3'b000);
    check({tag, "_eov_act_to"}, {end_of_video_out, frame_active, timeout_err}, 3'b000);
    check({tag, "_hdr"}, {width_out, height_out, interlaced_out}, 36'd0);
  endtask

  int base_send;
  int n;

  initial begin
    rst = 1'b0; vip_ctrl_valid = 1'b0; width_in = '0; height_in = '0; interlaced_in = '0;
    stall_in = 1'b0; stall_out = 1'b0; vip_ctrl_busy = 1'b0;

    // Reset state
    #2 rst = 1'b1;
    #1 check_rst_outputs("reset");
    step();
    step();
    check_rst_outputs("reset_hold");
    rst = 1'b0;
    step();

    // Nominal 4x2 frame, no stalls
    base_send = send_cnt;
    start_frame(16'd4, 16'd2, 4'd3);
    wait_frame_done("f1_done", 100);
    check("f1_hdr", {width_out, height_out, interlaced_out}, {16'd4, 16'd2, 4'd3});
    check("f1_send", send_cnt - base_send, 1);
    check("f1_reads", f_rd, 8);
    check("f1_rd_span", {first_rd, last_rd}, {32'd0, 32'd7});
    check("f1_writes", f_wr, 8);
    check("f1_wr_span", {first_wr, last_wr}, {32'd2, 32'd9});
    check("f1_eov", {f_eov, eov_idx}, {32'd1, 32'd8});

    // 4x2 frame with stall_out during frame cycles 3..5
    step();
    start_frame(16'd4, 16'd2, 4'd0);
    wait_active("f2_active", 20);
    step(); step(); step();
    stall_out = 1'b1;
    step(); step(); step();
    stall_out = 1'b0;
    wait_frame_done("f2_done", 100);
    check("f2_stall_cycles", stall_cyc, 3);
    check("f2_stall_rd_wr", {stall_rd, stall_wr}, 64'd0);
    check("f2_reads", {f_rd, last_rd}, {32'd8, 32'd10});
    check("f2_wr_first_second", {first_wr, wr2}, {32'd2, 32'd6});
    check("f2_writes", {f_wr, last_wr}, {32'd8, 32'd12});
    check("f2_eov", {f_eov, eov_idx}, {32'd1, 32'd8});

    // Zero width / zero height are ignored
    base_send = send_cnt;
    start_frame(16'd0, 16'd5, 4'd0);
    step(); step(); step(); step();
    check("zero_w_idle", {frame_active, vip_ctrl_send}, 2'b00);
    start_frame(16'd3, 16'd0, 4'd0);
    step(); step(); step(); step();
    check("zero_h_idle", frame_active, 1'b0);
    check("zero_no_send", send_cnt - base_send, 0);
    check("zero_hdr_kept", width_out, 16'd4);

    // 1x1 frame with encoder busy for the first 3 SEND_CTRL cycles
    base_send = send_cnt;
    vip_ctrl_busy = 1'b1;
    start_frame(16'd1, 16'd1, 4'd0);
    step(); step(); step();
    check("busy_no_send", {vip_ctrl_send, frame_active}, 2'b00);
    check("busy_send_cnt", send_cnt - base_send, 0);
    vip_ctrl_busy = 1'b0;
    step();
    check("busy_send_pulse", vip_ctrl_send, 1'b1);
    step();
    check("busy_send_once", {vip_ctrl_send, frame_active}, 2'b01);
    wait_frame_done("f3_done", 50);
    check("f3_send", send_cnt - base_send, 1);
    check("f3_rd_wr", {f_rd, f_wr}, {32'd1, 32'd1});
    check("f3_latency", {first_rd, first_wr}, {32'd0, 32'd2});
    check("f3_eov", {f_eov, eov_idx}, {32'd1, 32'd1});

    // Reset after 5 of 8 reads, then a fresh 2x2 frame
    step();
    start_frame(16'd4, 16'd2, 4'd5);
    wait_active("f4_active", 20);
    n = 0;
    while (f_rd < 5 && n < 50) begin
      step();
      n++;
    end
    check("f4_five_reads", f_rd, 5);
    rst = 1'b1;
    #1 check_rst_outputs("midrst");
    step();
    rst = 1'b0;
    step(); step(); step(); step();
    check("midrst_no_restart", frame_active, 1'b0);
    start_frame(16'd2, 16'd2, 4'd1);
    wait_frame_done("f5_done", 100);
    check("f5_rd_wr", {f_rd, f_wr}, {32'd4, 32'd4});
    check("f5_eov", {f_eov, eov_idx}, {32'd1, 32'd4});
    check("f5_hdr", {width_out, height_out, interlaced_out}, {16'd2, 16'd2, 4'd1});

`ifdef VIP_SEQ_TIMEOUT_EN
    // Watchdog: stall_in held high for the whole frame
    step();
    stall_in = 1'b1;
    start_frame(16'd4, 16'd2, 4'd0);
    wait_active("wd_active", 20);
    n = 0;
    while (!timeout_err && n < 40) begin
      step();
      n++;
    end
    check("wd_cycles", n, 16);
    check("wd_idle", frame_active, 1'b0);
    step(); step();
    check("wd_sticky", timeout_err, 1'b1);
    stall_in = 1'b0;
    rst = 1'b1;
    #1 check("wd_rst_clear", timeout_err, 1'b0);
    step();
    rst = 1'b0;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
